// File: rtl/sht10_responder_if.sv
// -----------------------------------------------------------------------------
// sht10_responder_if
// Two-wire SCK/SDA link between an SHT10 controller (master) and the sensor-side
// responder (slave).
//   sck_in        : SCK level driven by the master
//   sda_in        : resolved open-drain SDA level (pulled up externally)
//   sda_drive_low : 1 = responder pulls SDA low, 0 = responder releases SDA
// The master side owns the line resolution, so it produces sda_in.
// -----------------------------------------------------------------------------
interface sht10_responder_if;
  logic sck_in;
  logic sda_in;
  logic sda_drive_low;

  modport master (output sck_in, output sda_in, input sda_drive_low);
  modport slave  (input sck_in, input sda_in, output sda_drive_low);
endinterface

// File: rtl/sht10_responder.sv
// -----------------------------------------------------------------------------
// sht10_responder
// Sensor-side SHT10 emulator. Detects a Transmission Start, receives an 8-bit
// command, ACKs valid commands, waits a programmable conversion time, signals
// data-ready by pulling SDA low, then shifts out the result MSB/LSB and,
// optionally, a CRC byte.
//
// Ports
//   clock         : system clock
//   reset         : synchronous, active-high reset
//   bus           : SCK/SDA link (slave modport); SCK/SDA are asynchronous
//   temp_value    : 14-bit temperature word returned for command 0x03
//   rh_value      : 12-bit humidity word returned for command 0x05
//   busy          : high whenever the FSM is not IDLE
//   meas_done     : 1-cycle pulse on entry to READY
//   cmd_err       : 1-cycle pulse when an unsupported command was received
//   state         : current FSM state code (debug)
//
// Build option
//   SHT10_RESP_CRC_EN : when defined, a bit-reversed CRC-8 (poly 0x31, init 0)
//                       over cmd/MSB/LSB follows the LSB when the master ACKs it.
//                       When undefined, the frame ends after the LSB ACK slot.
// -----------------------------------------------------------------------------
module sht10_responder #(
  parameter int MEAS_CYC_TEMP = 20000,
  parameter int MEAS_CYC_RH   = 8000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clock,
  input  logic              reset,
  sht10_responder_if.slave  bus,
  input  logic [13:0]       temp_value,
  input  logic [11:0]       rh_value,
  output logic              busy,
  output logic              meas_done,
  output logic              cmd_err,
  output logic [3:0]        state
);

  localparam int CNT_MAX = (MEAS_CYC_TEMP > MEAS_CYC_RH) ? MEAS_CYC_TEMP : MEAS_CYC_RH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TEMP_LOAD = CNT_W'(MEAS_CYC_TEMP - 1);
  localparam logic [CNT_W-1:0] RH_LOAD   = CNT_W'(MEAS_CYC_RH - 1);

  localparam logic [7:0] CMD_TEMP     = 8'h03;
  localparam logic [7:0] CMD_RH       = 8'h05;
  localparam logic [7:0] CMD_SOFT_RST = 8'h1E;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_CMD     = 4'd1,  S_CMD_ACK = 4'd2,  S_MEASURE = 4'd3,
    S_READY   = 4'd4,  S_TX_MSB  = 4'd5,  S_ACK_MSB = 4'd6,  S_TX_LSB  = 4'd7,
    S_ACK_LSB = 4'd8,  S_TX_CRC  = 4'd9,  S_ACK_CRC = 4'd10
  } state_t;

  // Transmission Start tracker: SDA fall (SCK high) -> SCK fall -> SCK rise -> SDA rise.
  typedef enum logic [1:0] {TS_IDLE, TS_ARMED, TS_LOW, TS_HIGH} ts_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync, sda_sync;
  logic sck_d, sda_d;

  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the reset here is synchronous, so it
  // lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync <= '0;
      sda_sync <= '1;
      sck_d    <= 1'b0;
      sda_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      sck_d    <= sck_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, sda_s, sck_rise, sck_fall, sda_rise, sda_fall;
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign sda_rise =  sda_s & ~sda_d;
  assign sda_fall = ~sda_s &  sda_d;

`ifdef SHT10_RESP_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_nxt;
  ts_t              ts_q, ts_nxt;
  logic             ts_start;
  logic [3:0]       bit_cnt_q, bit_cnt_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic [7:0]       cmd_q, cmd_nxt;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_nxt;
  logic [7:0]       msb_q, msb_nxt, lsb_q, lsb_nxt, tx_byte;
  logic             ack_q, ack_nxt, drive_q, drive_nxt;
  logic             meas_done_nxt, cmd_err_nxt;
`ifdef SHT10_RESP_CRC_EN
  logic [7:0]       crc_q, crc_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ts_q       <= TS_IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      cmd_q      <= '0;
      meas_cnt_q <= '0;
      msb_q      <= '0;
      lsb_q      <= '0;
      ack_q      <= 1'b0;
      drive_q    <= 1'b0;
      meas_done  <= 1'b0;
      cmd_err    <= 1'b0;
`ifdef SHT10_RESP_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_nxt;
      ts_q       <= ts_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      idx_q      <= idx_nxt;
      cmd_q      <= cmd_nxt;
      meas_cnt_q <= meas_cnt_nxt;
      msb_q      <= msb_nxt;
      lsb_q      <= lsb_nxt;
      ack_q      <= ack_nxt;
      drive_q    <= drive_nxt;
      meas_done  <= meas_done_nxt;
      cmd_err    <= cmd_err_nxt;
`ifdef SHT10_RESP_CRC_EN
      crc_q      <= crc_nxt;
`endif
    end
  end

  assign bus.sda_drive_low = drive_q;
  assign busy              = (state_q != S_IDLE);
  assign state             = state_q;

  // ---------------------------------------------------------------------------
  // Transmission Start detector (active in every state)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path through the case/if tree can leave it unassigned (no latch).
  always_comb begin
    ts_nxt   = ts_q;
    ts_start = 1'b0;
    if (sda_fall && sck_s) begin
      ts_nxt = TS_ARMED;
    end else begin
      case (ts_q)
        TS_ARMED: if (sck_fall) ts_nxt = TS_LOW;  else if (sda_rise) ts_nxt = TS_IDLE;
        TS_LOW:   if (sck_rise) ts_nxt = TS_HIGH; else if (sda_rise || sda_fall) ts_nxt = TS_IDLE;
        TS_HIGH: begin
          if (sda_rise) begin
            ts_start = 1'b1;
            ts_nxt   = TS_IDLE;
          end else if (sck_fall) begin
            ts_nxt = TS_IDLE;
          end
        end
        default: ts_nxt = TS_IDLE;
      endcase
    end
  end

  // Result bytes as they will be latched when the conversion ends.
  logic [7:0] res_msb, res_lsb;
  assign res_msb = (cmd_q == CMD_TEMP) ? {2'b00, temp_value[13:8]} : {4'h0, rh_value[11:8]};
  assign res_lsb = (cmd_q == CMD_TEMP) ? temp_value[7:0] : rh_value[7:0];

  always_comb begin
    tx_byte = msb_q;
    if (state_q == S_TX_LSB) tx_byte = lsb_q;
`ifdef SHT10_RESP_CRC_EN
    if (state_q == S_TX_CRC) tx_byte = crc_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Main FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q;
    idx_nxt       = idx_q;
    cmd_nxt       = cmd_q;
    meas_cnt_nxt  = meas_cnt_q;
    msb_nxt       = msb_q;
    lsb_nxt       = lsb_q;
    ack_nxt       = ack_q;
    drive_nxt     = drive_q;
    meas_done_nxt = 1'b0;
    cmd_err_nxt   = 1'b0;
`ifdef SHT10_RESP_CRC_EN
    crc_nxt       = crc_q;
`endif

    if (ts_start) begin
      // A start aborts whatever frame is in progress.
      state_nxt   = S_CMD;
      bit_cnt_nxt = '0;
      drive_nxt   = 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (sck_rise && bit_cnt_q != 4'd8) begin
            cmd_nxt     = {cmd_q[6:0], sda_s};
            bit_cnt_nxt = bit_cnt_q + 4'd1;
          end else if (sck_fall && bit_cnt_q == 4'd8) begin
            if (cmd_q == CMD_TEMP || cmd_q == CMD_RH || cmd_q == CMD_SOFT_RST) begin
              drive_nxt = 1'b1;
              state_nxt = S_CMD_ACK;
            end else begin
              cmd_err_nxt = 1'b1;
              state_nxt   = S_IDLE;
            end
          end
        end

        S_CMD_ACK: begin
          if (sck_fall) begin
            drive_nxt = 1'b0;
            if (cmd_q == CMD_SOFT_RST) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt    = S_MEASURE;
              meas_cnt_nxt = (cmd_q == CMD_TEMP) ? TEMP_LOAD : RH_LOAD;
            end
          end
        end

        S_MEASURE: begin
          if (meas_cnt_q == '0) begin
            msb_nxt       = res_msb;
            lsb_nxt       = res_lsb;
`ifdef SHT10_RESP_CRC_EN
            crc_nxt       = bitrev8(crc8_byte(crc8_byte(crc8_byte(8'h00, cmd_q), res_msb), res_lsb));
`endif
            drive_nxt     = 1'b1;
            meas_done_nxt = 1'b1;
            state_nxt     = S_READY;
          end else begin
            meas_cnt_nxt = meas_cnt_q - CNT_W'(1);
          end
        end

        // MSB bit 7 is always 0, so the data-ready low already presents it.
        S_READY: begin
          if (sck_rise) begin
            state_nxt = S_TX_MSB;
            idx_nxt   = 3'd7;
          end
        end

        S_TX_MSB, S_TX_LSB, S_TX_CRC: begin
          if (sck_fall) begin
            if (idx_q == 3'd0) begin
              drive_nxt = 1'b0;
              case (state_q)
                S_TX_MSB: state_nxt = S_ACK_MSB;
                S_TX_LSB: state_nxt = S_ACK_LSB;
                default:  state_nxt = S_ACK_CRC;
              endcase
            end else begin
              idx_nxt   = idx_q - 3'd1;
              drive_nxt = ~tx_byte[idx_q - 3'd1];
            end
          end
        end

        S_ACK_MSB, S_ACK_LSB, S_ACK_CRC: begin
          if (sck_rise) begin
            ack_nxt = ~sda_s;
          end else if (sck_fall) begin
            state_nxt = S_IDLE;
            drive_nxt = 1'b0;
            if (state_q == S_ACK_MSB && ack_q) begin
              state_nxt = S_TX_LSB;
              idx_nxt   = 3'd7;
              drive_nxt = ~lsb_q[7];
            end
`ifdef SHT10_RESP_CRC_EN
            else if (state_q == S_ACK_LSB && ack_q) begin
              state_nxt = S_TX_CRC;
              idx_nxt   = 3'd7;
              drive_nxt = ~crc_q[7];
            end
`endif
          end
        end

        // IDLE ignores SCK/SDA activity, including the connection-reset clocks.
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
